// File: rtl/gcd_pack.sv
// Shared types and constants for the GCD request scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gcd_pack;

    // Operand and result width seen by requesters and the engine
    localparam int DATA_W      = 32;

    // Default sizing of the scheduler
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TIMEOUT = 1024;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/gcd_sched_rr_arbiter.sv
// Round-robin grant picker: one-hot grant to the first requester after last_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
// Ports: req_i request vector, last_i index of last served requester,
//        gnt_o one-hot grant (zero when no request), gnt_idx_o binary index of gnt_o.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     gnt_idx_o
);

    logic found;

    // Two passes: first the indices above the last winner, then wrap to the
    // bottom. The second pass only reaches indices <= last_i, since any
    // higher requester would already have been taken by the first.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i] && (IDW'(i) > last_i)) begin
                gnt_o[i]  = 1'b1;
                gnt_idx_o = IDW'(i);
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i]) begin
                gnt_o[i]  = 1'b1;
                gnt_idx_o = IDW'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_sched.sv
// Shares one GCD engine among NUM_REQ requesters with round-robin grant and per-job timeout.
// Latency: 5 cycles grant-to-ack minimum (IDLE, ISSUE, ARM, WAIT, RESP); at most 4+TIMEOUT.
// Backpressure: one job in flight; other requesters hold req until their ack pulse.
// Ports: req/req_a/req_b requester side, ack/resp_result/resp_err response side,
//        eng_start/eng_a/eng_b/eng_done/eng_result engine side, busy = not IDLE.
module gcd_sched
    import gcd_pack::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         resp_result,
    output logic                      resp_err,
    output logic                      eng_start,
    output logic [DATA_W-1:0]         eng_a,
    output logic [DATA_W-1:0]         eng_b,
    input  logic                      eng_done,
    input  logic [DATA_W-1:0]         eng_result,
    output logic                      busy
);

    localparam int IDW   = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]       gidx_q, gidx_d;
    logic [IDW-1:0]       last_q, last_d;
    logic [DATA_W-1:0]    a_q, a_d;
    logic [DATA_W-1:0]    b_q, b_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    res_q, res_d;
    logic                 err_q, err_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDW-1:0]       arb_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req_i     (req),
        .last_i    (last_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            // Last winner = top index, so index 0 wins first after reset
            last_q  <= IDW'(NUM_REQ - 1);
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d  = arb_gnt;
                    gidx_d = arb_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (arb_gnt[i]) begin
                            a_d = req_a[i*DATA_W +: DATA_W];
                            b_d = req_b[i*DATA_W +: DATA_W];
                        end
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_ARM;
            end
            // Engine still shows the previous done level this cycle
            ST_ARM: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Done is tested first so it wins a same-cycle timeout
                if (eng_done) begin
                    res_d   = eng_result;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                last_d  = gidx_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign eng_start   = (state_q == ST_ISSUE);
    assign ack         = (state_q == ST_RESP) ? gnt_q : '0;
    assign busy        = (state_q != ST_IDLE);
    assign eng_a       = a_q;
    assign eng_b       = b_q;
    assign resp_result = res_q;
    assign resp_err    = err_q;

endmodule
